// File: rtl/enoc_alloc_pkg.sv
// Shared types and helpers for the ENoC switch allocator.
// Port indices follow the route calculator request bit order.
package enoc_alloc_pkg;

    localparam int PORT_C  = 0;
    localparam int PORT_N  = 1;
    localparam int PORT_E  = 2;
    localparam int PORT_S  = 3;
    localparam int PORT_W  = 4;
    localparam int PORT_ZM = 5;
    localparam int PORT_ZP = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    // True when exactly one bit is set; callers zero-extend narrower vectors.
    function automatic logic onehot_valid(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/enoc_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping modulo PORTS.
module enoc_rr_arbiter
    import enoc_alloc_pkg::*;
#(
    parameter  int PORTS = 7,
    localparam int PTR_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PORTS-1:0] grant
);

    int               sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        for (int off = 0; off < PORTS; off++) begin
            sum = int'(ptr) + off;
            if (sum >= PORTS) begin
                sum = sum - PORTS;
            end
            idx = PTR_W'(sum);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enoc_switch_allocator.sv
// Wormhole switch allocator: one round-robin lock FSM per output port; an
// input holds its output from allocation until its tail flit transfers.
module enoc_switch_allocator
    import enoc_alloc_pkg::*;
#(
    parameter int PORTS = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [0:PORTS-1][0:PORTS-1]   i_output_req,
    input  logic [0:PORTS-1]              i_val,
    input  logic [0:PORTS-1]              i_tail,
    input  logic [0:PORTS-1]              i_en,
    output logic [0:PORTS-1]              o_grant,
    output logic [0:PORTS-1][0:PORTS-1]   o_xbar_sel,
    output logic [0:PORTS-1]              o_val,
    output logic                          o_err
);

    localparam int PTR_W = $clog2(PORTS);

    // Internal vectors are descending so bitwise ops align by port index.
    logic [PORTS-1:0]            val_v;
    logic [PORTS-1:0]            tail_v;
    logic [PORTS-1:0]            en_v;
    logic [PORTS-1:0][PORTS-1:0] req_v;     // [input][output]
    logic [PORTS-1:0]            req_ok;
    logic [PORTS-1:0]            bad_req;
    logic [PORTS-1:0]            busy;
    logic [PORTS-1:0][PORTS-1:0] sel_all;   // [output][input]
    logic [PORTS-1:0]            xfer_all;

    always_comb begin
        val_v  = '0;
        tail_v = '0;
        en_v   = '0;
        req_v  = '0;
        for (int i = 0; i < PORTS; i++) begin
            val_v[i]  = i_val[i];
            tail_v[i] = i_tail[i];
            en_v[i]   = i_en[i];
            for (int o = 0; o < PORTS; o++) begin
                req_v[i][o] = i_output_req[i][o];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_input
            assign req_ok[gi]  = val_v[gi] & onehot_valid(32'(req_v[gi]));
            assign bad_req[gi] = val_v[gi] & (req_v[gi] != '0)
                               & ~onehot_valid(32'(req_v[gi]));
        end
    endgenerate

    // An input that already owns an output may not compete for another.
    always_comb begin
        busy = '0;
        for (int o = 0; o < PORTS; o++) begin
            busy = busy | sel_all[o];
        end
    end

    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_output
            alloc_state_t     state_q, state_d;
            logic [PORTS-1:0] sel_q, sel_d;
            logic [PTR_W-1:0] ptr_q, ptr_d;
            logic [PORTS-1:0] cand;
            logic [PORTS-1:0] arb_gnt;
            logic [PTR_W-1:0] owner_next;
            logic             xfer;
            logic             xfer_tail;

            always_comb begin
                cand = '0;
                for (int i = 0; i < PORTS; i++) begin
                    cand[i] = req_ok[i] & req_v[i][gi] & ~busy[i];
                end
            end

            enoc_rr_arbiter #(.PORTS(PORTS)) u_arb (
                .req   (cand),
                .ptr   (ptr_q),
                .grant (arb_gnt)
            );

            // sel_q is zero while IDLE, so these only fire for a locked owner.
            assign xfer      = (|(sel_q & val_v)) & en_v[gi];
            assign xfer_tail = xfer & (|(sel_q & tail_v));

            always_comb begin
                owner_next = '0;
                for (int i = 0; i < PORTS; i++) begin
                    if (sel_q[i]) begin
                        owner_next = (i == PORTS - 1) ? '0 : PTR_W'(i + 1);
                    end
                end
            end

            always_comb begin
                state_d = state_q;
                sel_d   = sel_q;
                ptr_d   = ptr_q;
                case (state_q)
                    IDLE: begin
                        if (|cand) begin
                            state_d = LOCKED;
                            sel_d   = arb_gnt;
                        end
                    end
                    LOCKED: begin
                        if (xfer_tail) begin
                            state_d = IDLE;
                            sel_d   = '0;
                            ptr_d   = owner_next;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        sel_d   = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= IDLE;
                    sel_q   <= '0;
                    ptr_q   <= '0;
                end else begin
                    state_q <= state_d;
                    sel_q   <= sel_d;
                    ptr_q   <= ptr_d;
                end
            end

            assign sel_all[gi]  = sel_q;
            assign xfer_all[gi] = xfer;
        end
    endgenerate

    always_comb begin
        o_grant    = '0;
        o_val      = '0;
        o_xbar_sel = '0;
        for (int o = 0; o < PORTS; o++) begin
            o_val[o] = xfer_all[o];
            for (int i = 0; i < PORTS; i++) begin
                o_xbar_sel[o][i] = sel_all[o][i];
                if (xfer_all[o] && sel_all[o][i]) begin
                    o_grant[i] = 1'b1;
                end
            end
        end
    end

    assign o_err = ~reset & (|bad_req);

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Directed vector bench for enoc_switch_allocator: a per-cycle table plus
// hand-written backpressure, error and mid-packet reset sequences.
module tb_enoc_switch_allocator;

    localparam int P = 7;
    localparam logic [27:0] NONE   = 28'hFFFFFFF;
    localparam logic [6:0]  EN_ALL = 7'b1111111;

    logic               clk = 1'b0;
    logic               reset;
    logic [0:P-1][0:P-1] i_output_req;
    logic [0:P-1]       i_val, i_tail, i_en;
    logic [0:P-1]       o_grant, o_val;
    logic [0:P-1][0:P-1] o_xbar_sel;
    logic               o_err;

    always #5 clk = ~clk;

    enoc_switch_allocator #(.PORTS(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_output_req (i_output_req),
        .i_val        (i_val),
        .i_tail       (i_tail),
        .i_en         (i_en),
        .o_grant      (o_grant),
        .o_xbar_sel   (o_xbar_sel),
        .o_val        (o_val),
        .o_err        (o_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // dst: per-input requested output nibble (F = none);
    // src: per-output expected source input nibble (F = idle).
    typedef struct {
        logic [0:P-1][3:0] dst;
        logic [0:P-1]      val;
        logic [0:P-1]      tail;
        logic [0:P-1]      en;
        logic [0:P-1]      grant;
        logic [0:P-1]      oval;
        logic              err;
        logic [0:P-1][3:0] src;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic [27:0] dst, input logic [6:0] val,
                                input logic [6:0] tail, input logic [6:0] en,
                                input logic [6:0] grant, input logic [6:0] oval,
                                input logic err, input logic [27:0] src);
        vec_t v;
        v.dst = dst; v.val = val; v.tail = tail; v.en = en;
        v.grant = grant; v.oval = oval; v.err = err; v.src = src;
        return v;
    endfunction

    function automatic logic [0:P-1][0:P-1] dst_to_req(input logic [0:P-1][3:0] dst);
        logic [0:P-1][0:P-1] r;
        r = '0;
        for (int i = 0; i < P; i++) begin
            if (dst[i] != 4'hF) r[i][int'(dst[i])] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [0:P-1][0:P-1] src_to_sel(input logic [0:P-1][3:0] src);
        logic [0:P-1][0:P-1] s;
        s = '0;
        for (int o = 0; o < P; o++) begin
            if (src[o] != 4'hF) s[o][int'(src[o])] = 1'b1;
        end
        return s;
    endfunction

    task automatic check(input string name, input int row,
                         input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, row, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int row,
                            input logic [6:0] grant, input logic [6:0] oval,
                            input logic err, input logic [27:0] src);
        logic [0:P-1][3:0] s;
        s = src;
        check({tag, ".grant"}, row, 64'(o_grant), 64'(grant));
        check({tag, ".oval"},  row, 64'(o_val),   64'(oval));
        check({tag, ".err"},   row, 64'(o_err),   64'(err));
        check({tag, ".xbar"},  row, 64'(o_xbar_sel), 64'(src_to_sel(s)));
        $display("%s[%0d] grant=%b val=%b err=%b", tag, row, o_grant, o_val, o_err);
    endtask

    task automatic apply(input logic [27:0] dst, input logic [6:0] val,
                         input logic [6:0] tail, input logic [6:0] en);
        logic [0:P-1][3:0] d;
        d = dst;
        i_output_req = dst_to_req(d);
        i_val  = val;
        i_tail = tail;
        i_en   = en;
    endtask

    initial begin
        //                dst          val         tail        en      grant       oval       err src
        tbl[0]  = mk(28'hF2FFFFF, 7'b0100000, 7'b0100000, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);
        tbl[1]  = mk(28'hF2FFFFF, 7'b0100000, 7'b0100000, EN_ALL, 7'b0100000, 7'b0010000, 0, 28'hFF1FFFF);
        tbl[2]  = mk(NONE,        7'b0000000, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);
        tbl[3]  = mk(28'h6FF6F6F, 7'b1001010, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);
        tbl[4]  = mk(28'h6FF6F6F, 7'b1001010, 7'b0000000, EN_ALL, 7'b1000000, 7'b0000001, 0, 28'hFFFFFF0);
        tbl[5]  = mk(28'h6FF6F6F, 7'b1001010, 7'b1000000, EN_ALL, 7'b1000000, 7'b0000001, 0, 28'hFFFFFF0);
        tbl[6]  = mk(28'h6FF6F6F, 7'b1001010, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);
        tbl[7]  = mk(28'h6FF6F6F, 7'b1001010, 7'b0000000, EN_ALL, 7'b0001000, 7'b0000001, 0, 28'hFFFFFF3);
        tbl[8]  = mk(28'h6FF6F6F, 7'b1001010, 7'b0001000, EN_ALL, 7'b0001000, 7'b0000001, 0, 28'hFFFFFF3);
        tbl[9]  = mk(28'h6FF6F6F, 7'b1000010, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);
        tbl[10] = mk(28'h6FF6F6F, 7'b1000010, 7'b0000000, EN_ALL, 7'b0000010, 7'b0000001, 0, 28'hFFFFFF5);
        tbl[11] = mk(28'h6FF6F6F, 7'b1000010, 7'b0000010, EN_ALL, 7'b0000010, 7'b0000001, 0, 28'hFFFFFF5);
        tbl[12] = mk(28'h6FFFFF6, 7'b1000001, 7'b1000001, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);
        tbl[13] = mk(28'h6FFFFF6, 7'b1000001, 7'b1000001, EN_ALL, 7'b0000001, 7'b0000001, 0, 28'hFFFFFF6);
        tbl[14] = mk(28'h6FFFFF6, 7'b1000000, 7'b1000000, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);
        tbl[15] = mk(28'h6FFFFF6, 7'b1000000, 7'b1000000, EN_ALL, 7'b1000000, 7'b0000001, 0, 28'hFFFFFF0);
        tbl[16] = mk(28'hFF0F0FF, 7'b0000100, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);
        tbl[17] = mk(28'hFF0F0FF, 7'b0000100, 7'b0000000, EN_ALL, 7'b0000100, 7'b1000000, 0, 28'h4FFFFFF);
        tbl[18] = mk(28'hFF0F0FF, 7'b0010000, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, 28'h4FFFFFF);
        tbl[19] = mk(28'hFF0F0FF, 7'b0010000, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, 28'h4FFFFFF);
        tbl[20] = mk(28'hFF0F0FF, 7'b0010000, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, 28'h4FFFFFF);
        tbl[21] = mk(28'hFF0F0FF, 7'b0010100, 7'b0000100, EN_ALL, 7'b0000100, 7'b1000000, 0, 28'h4FFFFFF);
        tbl[22] = mk(28'hFF0F0FF, 7'b0010000, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);
        tbl[23] = mk(28'hFF0F0FF, 7'b0010000, 7'b0010000, EN_ALL, 7'b0010000, 7'b1000000, 0, 28'h2FFFFFF);
        tbl[24] = mk(NONE,        7'b0000000, 7'b0000000, EN_ALL, 7'b0000000, 7'b0000000, 0, NONE);

        reset = 1'b1;
        apply(NONE, 7'b0, 7'b0, EN_ALL);
        repeat (2) @(negedge clk);
        #1;
        chk_outs("reset", 0, 7'b0, 7'b0, 1'b0, NONE);

        for (int r = 0; r < 25; r++) begin
            @(negedge clk);
            reset = 1'b0;
            apply(tbl[r].dst, tbl[r].val, tbl[r].tail, tbl[r].en);
            #1;
            chk_outs("tbl", r, tbl[r].grant, tbl[r].oval, tbl[r].err, tbl[r].src);
        end

        // Backpressure: input 2 holds output 3 while i_en[3] is low.
        @(negedge clk);
        apply(28'hFF3FFFF, 7'b0010000, 7'b0000000, EN_ALL);
        #1;
        chk_outs("bp", 0, 7'b0, 7'b0, 1'b0, NONE);
        @(negedge clk);
        apply(28'hFF3FFFF, 7'b0010000, 7'b0000000, EN_ALL);
        #1;
        chk_outs("bp", 1, 7'b0010000, 7'b0001000, 1'b0, 28'hFFF2FFF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            apply(28'hFF3FFFF, 7'b0010000, 7'b0010000, 7'b1110111);
            #1;
            chk_outs("bp_stall", k, 7'b0, 7'b0, 1'b0, 28'hFFF2FFF);
        end
        @(negedge clk);
        apply(28'hFF3FFFF, 7'b0010000, 7'b0010000, EN_ALL);
        #1;
        chk_outs("bp", 2, 7'b0010000, 7'b0001000, 1'b0, 28'hFFF2FFF);
        @(negedge clk);
        apply(NONE, 7'b0, 7'b0, EN_ALL);
        #1;
        chk_outs("bp", 3, 7'b0, 7'b0, 1'b0, NONE);

        // Non-one-hot request flags an error and takes no lock.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            apply(NONE, 7'b0000001, 7'b0000001, EN_ALL);
            i_output_req[6] = 7'b0011000;
            #1;
            chk_outs("err", k, 7'b0, 7'b0, 1'b1, NONE);
        end
        // All-zero request with valid: excluded, but not an error.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            apply(NONE, 7'b0000001, 7'b0000001, EN_ALL);
            #1;
            chk_outs("zero_req", k, 7'b0, 7'b0, 1'b0, NONE);
        end

        // Reset while output 1 is LOCKED(0); output 6 pointer was left at 1.
        @(negedge clk);
        apply(28'h1FFFFFF, 7'b1000000, 7'b0000000, EN_ALL);
        #1;
        chk_outs("rst_mid", 0, 7'b0, 7'b0, 1'b0, NONE);
        @(negedge clk);
        apply(28'h1FFFFFF, 7'b1000000, 7'b0000000, EN_ALL);
        #1;
        chk_outs("rst_mid", 1, 7'b1000000, 7'b0100000, 1'b0, 28'hF0FFFFF);
        @(negedge clk);
        reset = 1'b1;
        i_output_req[6] = 7'b0011000;
        i_val = 7'b1000001;
        @(negedge clk);
        #1;
        chk_outs("rst_mid", 2, 7'b0, 7'b0, 1'b0, NONE);
        @(negedge clk);
        reset = 1'b0;
        apply(28'h6FFFFF6, 7'b1000001, 7'b1000001, EN_ALL);
        #1;
        chk_outs("rst_ptr", 0, 7'b0, 7'b0, 1'b0, NONE);
        @(negedge clk);
        apply(28'h6FFFFF6, 7'b1000001, 7'b1000001, EN_ALL);
        #1;
        chk_outs("rst_ptr", 1, 7'b1000000, 7'b0000001, 1'b0, 28'hFFFFFF0);
        @(negedge clk);
        apply(NONE, 7'b0, 7'b0, EN_ALL);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/enoc_switch_allocator.md
Name: enoc_switch_allocator

Overview:
Wormhole switch allocator for the ENoC router. It takes the one-hot output-port requests that each input port's route calculator produces and shares every output port between the inputs that request it. Each output has a round-robin arbiter. A winning input holds the output until its tail flit is transferred. The block drives per-input pop grants and per-output crossbar select lines.

Parameters:
PORTS, 7, number of router ports; index order c, n, e, s, w, z-, z+ (0..6), matching route calculator request bit order.

Ports:
clk  input  1  router clock
reset  input  1  synchronous, active-high reset
i_output_req  input  [0:PORTS-1][0:PORTS-1]  per input i, one-hot requested output vector (bit o = output o)
i_val  input  [0:PORTS-1]  input i has a flit at the FIFO head
i_tail  input  [0:PORTS-1]  head flit of input i is the packet tail (a single-flit packet sets head and tail)
i_en  input  [0:PORTS-1]  output o can accept a flit this cycle (downstream not full)
o_grant  output  [0:PORTS-1]  input i's flit transfers this cycle; pops the input FIFO
o_xbar_sel  output  [0:PORTS-1][0:PORTS-1]  per output o, one-hot source input; all-zero when idle
o_val  output  [0:PORTS-1]  output o carries a valid flit this cycle
o_err  output  1  pulse: some valid input presented a non-one-hot request

Behaviour:
- Reset (synchronous, active-high):
  - all outputs go IDLE; owner cleared; round-robin pointers go to 0.
  - o_xbar_sel = 0, o_grant = 0, o_val = 0, o_err = 0.
  - Reset asserted mid-packet drops all locks at once. Upstream must reset concurrently.
- Per-output FSM, states IDLE and LOCKED(owner):
  - IDLE: the candidate set is the inputs i with i_val[i] and i_output_req[i][o] and i not already an owner of any output.
    - If the set is non-empty, pick the first candidate at or after the pointer, wrapping modulo PORTS.
    - Move to LOCKED(winner) on the next edge.
    - Allocation latency is 1 cycle from request to lock.
  - LOCKED(k):
    - o_xbar_sel[o] = onehot(k), registered.
    - Transfer condition: i_val[k] & i_en[o]. When it holds, the same cycle combinationally gives o_grant[k] = 1 and o_val[o] = 1.
    - If a transfer happens with i_tail[k], go to IDLE next edge and set pointer = (k+1) mod PORTS.
    - If i_val[k] drops mid-packet, the lock is held with no transfer.
    - If i_en[o] is low, the lock is held and o_grant[k] = 0.
- Tail transfer and other pending requests in the same cycle: the output returns to IDLE and re-arbitrates in the following cycle. This gives one bubble cycle between packets on the same output.
- Each input owns at most one output (requests are one-hot), so o_grant is at most one transfer per input per cycle.
- Non-one-hot or all-zero request with i_val set:
  - the input is excluded from arbitration that cycle;
  - for non-one-hot only, o_err = 1 (combinational).
- Request bits are sampled only while IDLE; changes to i_output_req[k] while k owns an output are ignored until release.
- A request to the same port as the input (u-turn) is permitted; the block does not filter it.
- Pointer updates only on release, never on a grant without a tail, which guarantees starvation freedom.

Decomposition:
- Shared package enoc_alloc_pkg:
  - port index constants PORT_C..PORT_ZP (0..6);
  - state enum alloc_state_t {IDLE, LOCKED};
  - function onehot_valid() for the error check.
- Sub-module enoc_rr_arbiter (PORTS-wide request, pointer input, one-hot grant output, combinational), instantiated once per output by a generate loop. The lock FSM and pointer register stay in the parent.

Test Plan:
- Single-flit packet: input 1 requests output 2 (i_output_req[1] = 7'b0010000), i_val[1] = 1, i_tail[1] = 1, i_en[2] = 1.
  -> cycle 1: o_xbar_sel[2] = 7'b0100000, o_grant[1] = 1, o_val[2] = 1.
  -> cycle 2: output 2 IDLE, o_xbar_sel[2] = 0.
- Contention: inputs 0, 3 and 5 all request output 6 with 2-flit packets, pointer 0.
  -> grant order 0, 3, 5.
  -> each lock lasts 2 transfer cycles plus 1 bubble.
  -> the pointer is 1, 4, 6 after each release.
- Wormhole hold: input 4 locks output 0 and sends its head; i_val[4] goes low for 3 cycles while input 2 requests output 0.
  -> output 0 stays LOCKED(4); o_grant[2] = 0 throughout.
  -> input 2 wins only after input 4's tail.
- Backpressure: LOCKED(2) on output 3 with i_en[3] = 0 for 4 cycles.
  -> o_grant[2] = 0 and o_val[3] = 0 for 4 cycles.
  -> the flit transfers on the cycle i_en[3] returns to 1.
- Error plus reset mid-packet: input 6 presents 7'b0011000 with i_val = 1.
  -> o_err = 1; no lock is taken.
  -> then reset asserted while output 1 is LOCKED(0): next cycle o_xbar_sel = 0, o_grant = 0, pointers = 0.
